// File: rtl/l1_port_arbiter.sv
// l1_port_arbiter
// Shares the single unified L1 cache port between the instruction-fetch
// requester (imem) and the load/store requester (dmem). One access is in
// flight at a time. From idle, dmem wins. When one side completes while the
// other is waiting, the port hands over directly, which gives strict
// alternation under sustained contention. A watchdog forces completion of an
// access that the cache never acknowledges. Grant and contention counters are
// provided for debug.
`timescale 1ns/1ps
module l1_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 32
) (
  input  logic              clk,
  input  logic              reset,
  // instruction-fetch side
  input  logic              imem_req,
  input  logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_instn,
  output logic              imem_wait,
  // load/store side
  input  logic              dmem_req,
  input  logic              dmem_we,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_wd,
  input  logic [3:0]        dmem_mask,
  output logic [DATA_W-1:0] dmem_rd,
  output logic              dmem_wait,
  // unified L1 cache port
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  output logic [3:0]        mem_mask,
  input  logic [DATA_W-1:0] mem_rd,
  input  logic              mem_ack,
  // debug
  output logic              err_timeout,
  output logic [CNT_W-1:0]  cnt_igrant,
  output logic [CNT_W-1:0]  cnt_dgrant,
  output logic [CNT_W-1:0]  cnt_conflict
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } state_t;

  // The watchdog only needs to count up to TIMEOUT_CYCLES-1.
  localparam int               WDOG_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

  state_t             r_state;
  logic [WDOG_W-1:0]  r_wdog;
  logic               r_err_timeout;
  logic [CNT_W-1:0]   r_cnt_igrant;
  logic [CNT_W-1:0]   r_cnt_dgrant;
  logic [CNT_W-1:0]   r_cnt_conflict;

  logic w_busy;
  logic w_busy_i;
  logic w_busy_d;
  logic w_forced;
  logic w_done;
  logic w_grant_i;
  logic w_grant_d;
  logic w_imem_wait;
  logic w_dmem_wait;
  logic w_conflict;

  assign w_busy_i = (r_state == ST_BUSY_I);
  assign w_busy_d = (r_state == ST_BUSY_D);
  assign w_busy   = w_busy_i | w_busy_d;

  // Forced completion: the watchdog reached its last count and the cache
  // still has not acknowledged in this cycle.
  assign w_forced = w_busy & ~mem_ack & (r_wdog == WDOG_LAST);
  assign w_done   = w_busy & (mem_ack | w_forced);

  // Grants. From idle dmem has priority; on completion the port goes to the
  // other side if it is requesting, never back to the side just served.
  assign w_grant_d = ((r_state == ST_IDLE) & dmem_req) |
                     (w_busy_i & w_done & dmem_req);
  assign w_grant_i = ((r_state == ST_IDLE) & ~dmem_req & imem_req) |
                     (w_busy_d & w_done & imem_req);

  assign w_imem_wait = imem_req & ~(w_busy_i & w_done);
  assign w_dmem_wait = dmem_req & ~(w_busy_d & w_done);
  assign w_conflict  = imem_req & dmem_req & (w_imem_wait | w_dmem_wait);

  // Arbiter FSM together with the access watchdog and the sticky timeout flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_wdog        <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      if (w_grant_d) begin
        r_state <= ST_BUSY_D;
      end else if (w_grant_i) begin
        r_state <= ST_BUSY_I;
      end else if (w_done) begin
        r_state <= ST_IDLE;
      end

      // Count consecutive unacknowledged busy cycles of the current access.
      if (w_grant_d | w_grant_i | w_done | ~w_busy) begin
        r_wdog <= '0;
      end else begin
        r_wdog <= r_wdog + WDOG_W'(1);
      end

      if (w_forced) begin
        r_err_timeout <= 1'b1;
      end
    end
  end

  // Debug counters; they wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt_igrant   <= '0;
      r_cnt_dgrant   <= '0;
      r_cnt_conflict <= '0;
    end else begin
      if (w_grant_i) begin
        r_cnt_igrant <= r_cnt_igrant + CNT_W'(1);
      end
      if (w_grant_d) begin
        r_cnt_dgrant <= r_cnt_dgrant + CNT_W'(1);
      end
      if (w_conflict) begin
        r_cnt_conflict <= r_cnt_conflict + CNT_W'(1);
      end
    end
  end

  // Cache-side request mux, driven purely from the current owner.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    mem_mask = 4'h0;
    case (r_state)
      ST_BUSY_D: begin
        mem_req  = 1'b1;
        mem_we   = dmem_we;
        mem_addr = dmem_addr;
        mem_wd   = dmem_wd;
        mem_mask = dmem_mask;
      end
      ST_BUSY_I: begin
        mem_req  = 1'b1;
        mem_mask = 4'hF;
        mem_addr = imem_addr;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  // Returned data is passed only on a real acknowledge to the side being
  // served. A requester that abandoned its request mid-access gets nothing,
  // so the stale data from that access is discarded.
  assign imem_instn = (w_busy_i & mem_ack & imem_req) ? mem_rd : '0;
  assign dmem_rd    = (w_busy_d & mem_ack & dmem_req) ? mem_rd : '0;

  assign imem_wait    = w_imem_wait;
  assign dmem_wait    = w_dmem_wait;
  assign err_timeout  = r_err_timeout;
  assign cnt_igrant   = r_cnt_igrant;
  assign cnt_dgrant   = r_cnt_dgrant;
  assign cnt_conflict = r_cnt_conflict;

endmodule

// File: tb/tb_l1_port_arbiter.sv
// Testbench for l1_port_arbiter: directed scenarios followed by a randomized
// traffic phase checked by a scoreboard and a transaction-level port model.
`timescale 1ns/1ps
module tb_l1_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 64;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_instn;
  logic          imem_wait;
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wd;
  logic [3:0]    dmem_mask;
  logic [DW-1:0] dmem_rd;
  logic          dmem_wait;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic [3:0]    mem_mask;
  logic [DW-1:0] mem_rd;
  logic          mem_ack;
  logic          err_timeout;
  logic [CW-1:0] cnt_igrant;
  logic [CW-1:0] cnt_dgrant;
  logic [CW-1:0] cnt_conflict;

  l1_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_instn(imem_instn), .imem_wait(imem_wait),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wd(dmem_wd),
    .dmem_mask(dmem_mask), .dmem_rd(dmem_rd), .dmem_wait(dmem_wait),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_mask(mem_mask), .mem_rd(mem_rd), .mem_ack(mem_ack),
    .err_timeout(err_timeout), .cnt_igrant(cnt_igrant), .cnt_dgrant(cnt_dgrant),
    .cnt_conflict(cnt_conflict)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cache responder data: a fixed function of the address.
  function automatic logic [31:0] rdata(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wd;
    logic [3:0]    mask;
    logic [DW-1:0] rd;
  } txn_t;

  txn_t iq[$];
  txn_t dq[$];

  // Port model state: 0 = nobody owns the port, 1 = imem, 2 = dmem.
  int   m_owner;
  int   m_igr;
  int   m_dgr;
  int   m_conf;
  logic mon_en = 1'b0;

  task automatic pedge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    imem_req = 0; imem_addr = '0;
    dmem_req = 0; dmem_we = 0; dmem_addr = '0; dmem_wd = '0; dmem_mask = 4'h0;
    mem_ack = 0; mem_rd = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_in();
    pedge();
    reset = 0;
  endtask

  // Scoreboard monitor for the random phase.
  always @(negedge clk) begin
    logic done;
    logic exp_iw;
    logic exp_dw;
    txn_t t;
    if (mon_en) begin
      done   = (m_owner != 0) && mem_ack;
      exp_iw = imem_req && !(m_owner == 1 && done);
      exp_dw = dmem_req && !(m_owner == 2 && done);
      chk("rnd_imem_wait", 64'(imem_wait), 64'(exp_iw));
      chk("rnd_dmem_wait", 64'(dmem_wait), 64'(exp_dw));
      chk("rnd_mem_req", 64'(mem_req), 64'(m_owner != 0));
      if (m_owner == 2 && dq.size() > 0) begin
        chk("rnd_d_addr", 64'(mem_addr), 64'(dq[0].addr));
        chk("rnd_d_ctl", 64'({mem_we, mem_mask, mem_wd}), 64'({dq[0].we, dq[0].mask, dq[0].wd}));
      end else if (m_owner == 1 && iq.size() > 0) begin
        chk("rnd_i_addr", 64'(mem_addr), 64'(iq[0].addr));
        chk("rnd_i_ctl", 64'({mem_we, mem_mask, mem_wd}), 64'({1'b0, 4'hF, 32'h0}));
      end else if (m_owner == 0) begin
        chk("rnd_idle_addr", 64'(mem_addr), 64'h0);
        chk("rnd_idle_ctl", 64'({mem_we, mem_mask, mem_wd}), 64'h0);
      end
      // Completion seen on a requester: pop its expected response and compare.
      if (imem_req && !imem_wait) begin
        if (iq.size() > 0) begin
          t = iq.pop_front();
          chk("rnd_instn", 64'(imem_instn), 64'(t.rd));
        end else begin
          chk("rnd_i_unexpected", 64'(imem_wait), 64'h1);
        end
      end else begin
        chk("rnd_instn_zero", 64'(imem_instn), 64'h0);
      end
      if (dmem_req && !dmem_wait) begin
        if (dq.size() > 0) begin
          t = dq.pop_front();
          chk("rnd_drd", 64'(dmem_rd), 64'(t.rd));
        end else begin
          chk("rnd_d_unexpected", 64'(dmem_wait), 64'h1);
        end
      end else begin
        chk("rnd_drd_zero", 64'(dmem_rd), 64'h0);
      end
      if (imem_req && dmem_req && (exp_iw || exp_dw)) m_conf++;
      // Decide who owns the port next cycle.
      if (done) begin
        if (m_owner == 1) m_owner = dmem_req ? 2 : 0;
        else              m_owner = imem_req ? 1 : 0;
        if (m_owner == 1) m_igr++;
        else if (m_owner == 2) m_dgr++;
      end else if (m_owner == 0) begin
        m_owner = dmem_req ? 2 : (imem_req ? 1 : 0);
        if (m_owner == 1) m_igr++;
        else if (m_owner == 2) m_dgr++;
      end
    end
  end

  // Overall time limit.
  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  initial begin
    int   seen;
    logic i_fin;
    logic d_fin;
    txn_t nt;

    // ---------------- reset state ----------------
    reset = 1;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_mem_req", 64'(mem_req), 64'h0);
    chk("rst_err", 64'(err_timeout), 64'h0);
    chk("rst_cnts", 64'(cnt_igrant | cnt_dgrant | cnt_conflict), 64'h0);
    pedge();
    reset = 0;

    // ---------------- single load ----------------
    dmem_req = 1; dmem_we = 0; dmem_addr = 32'h100; dmem_mask = 4'hF;
    @(negedge clk);
    chk("ld_wait_idle", 64'(dmem_wait), 64'h1);
    chk("ld_memreq_idle", 64'(mem_req), 64'h0);
    pedge();
    mem_ack = 1; mem_rd = 32'hDEADBEEF;
    @(negedge clk);
    chk("ld_mem_req", 64'(mem_req), 64'h1);
    chk("ld_mem_addr", 64'(mem_addr), 64'h100);
    chk("ld_mem_we", 64'(mem_we), 64'h0);
    chk("ld_wait_ack", 64'(dmem_wait), 64'h0);
    chk("ld_rd", 64'(dmem_rd), 64'hDEADBEEF);
    pedge();
    dmem_req = 0; mem_ack = 0; mem_rd = '0;
    @(negedge clk);
    chk("ld_mem_req_after", 64'(mem_req), 64'h0);
    chk("ld_dgrant", 64'(cnt_dgrant), 64'h1);
    chk("ld_igrant", 64'(cnt_igrant), 64'h0);

    // ---------------- simultaneous requests ----------------
    do_reset();
    imem_req = 1; imem_addr = 32'h0;
    dmem_req = 1; dmem_we = 1; dmem_addr = 32'h200; dmem_wd = 32'h12345678; dmem_mask = 4'b0011;
    @(negedge clk);
    chk("sim_waits_idle", 64'({imem_wait, dmem_wait}), 64'h3);
    pedge();
    mem_ack = 1; mem_rd = 32'h0BADF00D;
    @(negedge clk);
    chk("sim_d_ctl", 64'({mem_req, mem_we, mem_mask}), 64'({1'b1, 1'b1, 4'b0011}));
    chk("sim_d_addr", 64'(mem_addr), 64'h200);
    chk("sim_d_wd", 64'(mem_wd), 64'h12345678);
    chk("sim_d_waits", 64'({imem_wait, dmem_wait}), 64'h2);
    pedge();
    dmem_req = 0; dmem_we = 0; mem_rd = 32'h13;
    @(negedge clk);
    chk("sim_i_ctl", 64'({mem_req, mem_we, mem_mask}), 64'({1'b1, 1'b0, 4'hF}));
    chk("sim_i_addr_wd", 64'({mem_addr, mem_wd}), 64'h0);
    chk("sim_instn", 64'(imem_instn), 64'h13);
    chk("sim_i_wait", 64'(imem_wait), 64'h0);
    pedge();
    imem_req = 0; mem_ack = 0;
    @(negedge clk);
    chk("sim_idle", 64'(mem_req), 64'h0);
    // both requests high with a waiter in the idle cycle and in the dmem ack cycle
    chk("sim_conflict", 64'(cnt_conflict), 64'h2);
    chk("sim_grants", 64'({cnt_igrant, cnt_dgrant}), {32'h1, 32'h1});

    // ---------------- sustained contention ----------------
    do_reset();
    imem_req = 1; imem_addr = 32'h40;
    dmem_req = 1; dmem_we = 0; dmem_addr = 32'h80; dmem_mask = 4'hF;
    mem_ack = 1; mem_rd = 32'h5;
    @(negedge clk);
    chk("alt_idle", 64'(mem_req), 64'h0);
    for (int k = 0; k < 6; k++) begin
      pedge();
      if (k == 5) dmem_req = 0;
      @(negedge clk);
      chk($sformatf("alt_order%0d", k), 64'(mem_addr), (k % 2 == 0) ? 64'h80 : 64'h40);
    end
    pedge();
    imem_req = 0; mem_ack = 0;
    @(negedge clk);
    chk("alt_end_idle", 64'(mem_req), 64'h0);
    chk("alt_grants", 64'({cnt_igrant, cnt_dgrant}), {32'h3, 32'h3});

    // ---------------- watchdog ----------------
    do_reset();
    imem_req = 1; imem_addr = 32'h44; mem_rd = 32'hFFFFFFFF;
    @(negedge clk);
    seen = 0;
    for (int k = 1; k <= TO + 16; k++) begin
      pedge();
      @(negedge clk);
      if (!imem_wait) begin
        seen = k;
        chk("to_instn", 64'(imem_instn), 64'h0);
        chk("to_mem_req", 64'(mem_req), 64'h1);
        break;
      end
    end
    chk("to_latency", 64'(seen), 64'(TO));
    pedge();
    imem_req = 0;
    @(negedge clk);
    chk("to_err_set", 64'(err_timeout), 64'h1);
    chk("to_idle", 64'(mem_req), 64'h0);
    repeat (3) pedge();
    @(negedge clk);
    chk("to_err_sticky", 64'(err_timeout), 64'h1);
    pedge();
    do_reset();
    @(negedge clk);
    chk("to_err_cleared", 64'(err_timeout), 64'h0);

    // ---------------- reset mid-access, stray ack ----------------
    pedge();
    dmem_req = 1; dmem_we = 1; dmem_addr = 32'h500; dmem_wd = 32'hAA; dmem_mask = 4'hF;
    pedge();
    @(negedge clk);
    chk("rb_busy", 64'(mem_req), 64'h1);
    #2;
    reset = 1; dmem_req = 0;
    #1;
    chk("rb_async_mem", 64'({mem_req, mem_we, mem_mask, mem_addr}), 64'h0);
    chk("rb_async_cnt", 64'(cnt_dgrant), 64'h0);
    pedge();
    reset = 0; mem_ack = 1; mem_rd = 32'h77;
    @(negedge clk);
    chk("rb_stray_mem", 64'(mem_req), 64'h0);
    chk("rb_stray_rd", 64'({dmem_rd, imem_instn}), 64'h0);
    chk("rb_stray_wait", 64'({dmem_wait, imem_wait}), 64'h0);
    pedge();
    mem_ack = 0;
    @(negedge clk);
    chk("rb_after", 64'({mem_req, cnt_dgrant}), 64'h0);

    // ---------------- requester drops mid-access ----------------
    do_reset();
    dmem_req = 1; dmem_we = 0; dmem_addr = 32'h300; dmem_mask = 4'hF;
    pedge();
    @(negedge clk);
    chk("dr_busy", 64'(mem_req), 64'h1);
    pedge();
    dmem_req = 0; imem_req = 1; imem_addr = 32'h48;
    @(negedge clk);
    chk("dr_held", 64'({mem_req, mem_addr}), 64'({1'b1, 32'h300}));
    chk("dr_waits", 64'({imem_wait, dmem_wait}), 64'h2);
    pedge();
    mem_ack = 1; mem_rd = 32'hCAFEF00D;
    @(negedge clk);
    chk("dr_discard", 64'(dmem_rd), 64'h0);
    chk("dr_dwait", 64'(dmem_wait), 64'h0);
    pedge();
    mem_rd = 32'h1111;
    @(negedge clk);
    chk("dr_next_addr", 64'(mem_addr), 64'h48);
    chk("dr_next_instn", 64'(imem_instn), 64'h1111);
    chk("dr_next_wait", 64'(imem_wait), 64'h0);
    pedge();
    imem_req = 0; mem_ack = 0;
    @(negedge clk);
    chk("dr_grants", 64'({cnt_igrant, cnt_dgrant}), {32'h1, 32'h1});

    // ---------------- randomized traffic ----------------
    pedge();
    do_reset();
    m_owner = 0; m_igr = 0; m_dgr = 0; m_conf = 0;
    iq.delete(); dq.delete();
    i_fin = 0; d_fin = 0;
    mon_en = 1;
    for (int cyc = 0; cyc < 3400; cyc++) begin
      bit issue;
      issue = (cyc < 3000);
      if (i_fin) imem_req = 0;
      if (d_fin) dmem_req = 0;
      if (issue && !imem_req && $urandom_range(0, 2) == 0) begin
        imem_addr = $urandom & 32'hFFFF_FFFC;
        imem_req  = 1;
        nt.addr = imem_addr; nt.we = 0; nt.wd = '0; nt.mask = 4'hF; nt.rd = rdata(imem_addr);
        iq.push_back(nt);
      end
      if (issue && !dmem_req && $urandom_range(0, 2) == 0) begin
        dmem_addr = $urandom;
        dmem_we   = ($urandom_range(0, 1) == 1);
        dmem_wd   = $urandom;
        dmem_mask = 4'($urandom_range(0, 15));
        dmem_req  = 1;
        nt.addr = dmem_addr; nt.we = dmem_we; nt.wd = dmem_wd; nt.mask = dmem_mask;
        nt.rd = rdata(dmem_addr);
        dq.push_back(nt);
      end
      if (!issue && !imem_req && !dmem_req) break;
      #1;
      mem_ack = mem_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
      mem_rd  = (mem_ack && mem_req) ? rdata(mem_addr) : $urandom;
      @(negedge clk);
      i_fin = imem_req && !imem_wait;
      d_fin = dmem_req && !dmem_wait;
      pedge();
    end
    chk("rnd_drained", 64'({imem_req, dmem_req}), 64'h0);
    mem_ack = 0;
    repeat (3) pedge();
    mon_en = 0;
    @(negedge clk);
    chk("rnd_igrant", 64'(cnt_igrant), 64'(m_igr));
    chk("rnd_dgrant", 64'(cnt_dgrant), 64'(m_dgr));
    chk("rnd_conflict", 64'(cnt_conflict), 64'(m_conf));
    chk("rnd_no_timeout", 64'(err_timeout), 64'h0);
    chk("rnd_queues_empty", 64'(iq.size() + dq.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
